// File: rtl/mem_block_responder.sv
// Block-sized backing memory for cache refill/writeback with programmable latency.
// Define MEM_STATS_EN to add saturating read/write/error counters.
module mem_block_responder #(
    parameter int BLOCK_SIZE = 64,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [BLOCK_SIZE*8-1:0] req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_write,
    output logic                    resp_err,
    output logic [BLOCK_SIZE*8-1:0] resp_data,
`ifdef MEM_STATS_EN
    output logic [15:0]             rd_count,
    output logic [15:0]             wr_count,
    output logic [15:0]             err_count,
`endif
    output logic                    busy
);

    localparam int DW  = BLOCK_SIZE * 8;
    localparam int OFF = $clog2(BLOCK_SIZE);
    localparam int IW  = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    logic [7:0]       cnt;
    logic [31:0]      addr_q;
    logic             wr_q;
    logic             err_q;
    logic [DW-1:0]    wdata_q;
    logic [MEM_DEPTH-1:0] written;
    logic [DW-1:0]    mem [MEM_DEPTH];
    logic [31:0]      blk_idx;
    logic [IW-1:0]    idx;
    logic             do_access;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign blk_idx   = req_addr >> OFF;
    assign idx       = addr_q[OFF +: IW];
    assign do_access = (state == WAIT) && (cnt == 8'd0);

    // Storage is intentionally unreset; the written bitmap decides validity.
    always_ff @(posedge clk) begin
        if (do_access && wr_q && !err_q)
            mem[idx] <= wdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            written    <= '0;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
`ifdef MEM_STATS_EN
            rd_count   <= 16'd0;
            wr_count   <= 16'd0;
            err_count  <= 16'd0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr & ~32'(BLOCK_SIZE - 1);
                        wr_q    <= req_write;
                        wdata_q <= req_wdata;
                        err_q   <= (blk_idx >= 32'(MEM_DEPTH));
                        cnt     <= 8'(LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 8'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_write <= wr_q;
                        resp_err   <= err_q;
                        if (err_q || wr_q)
                            resp_data <= '0;
                        else if (written[idx])
                            resp_data <= mem[idx];
                        else
                            resp_data <= {(BLOCK_SIZE/4){addr_q}};
                        if (wr_q && !err_q)
                            written[idx] <= 1'b1;
`ifdef MEM_STATS_EN
                        if (err_q) begin
                            if (err_count != 16'hFFFF)
                                err_count <= err_count + 16'd1;
                        end else if (wr_q) begin
                            if (wr_count != 16'hFFFF)
                                wr_count <= wr_count + 16'd1;
                        end else begin
                            if (rd_count != 16'hFFFF)
                                rd_count <= rd_count + 16'd1;
                        end
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_responder.sv
// Scoreboard bench for mem_block_responder (LATENCY=4 main, LATENCY=1 second instance).
module tb_mem_block_responder;

    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         req_valid, req_ready, req_write;
    logic [31:0]  req_addr;
    logic [511:0] req_wdata;
    logic         resp_valid, resp_ready, resp_write, resp_err;
    logic [511:0] resp_data;
    logic         busy;

    logic         req_valid1, req_ready1;
    logic [31:0]  req_addr1;
    logic         resp_valid1, resp_write1, resp_err1;
    logic [511:0] resp_data1;
    logic         busy1;

`ifdef MEM_STATS_EN
    logic [15:0] rd_c, wr_c, er_c, rd_c1, wr_c1, er_c1;
`endif

    mem_block_responder #(.LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_write(resp_write), .resp_err(resp_err), .resp_data(resp_data),
`ifdef MEM_STATS_EN
        .rd_count(rd_c), .wr_count(wr_c), .err_count(er_c),
`endif
        .busy(busy)
    );

    mem_block_responder #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_write(1'b0), .req_addr(req_addr1), .req_wdata(512'd0),
        .resp_valid(resp_valid1), .resp_ready(1'b1),
        .resp_write(resp_write1), .resp_err(resp_err1), .resp_data(resp_data1),
`ifdef MEM_STATS_EN
        .rd_count(rd_c1), .wr_count(wr_c1), .err_count(er_c1),
`endif
        .busy(busy1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         w;
        logic         e;
        logic [511:0] d;
        int           at;
    } exp_t;
    exp_t q[$];

    task automatic chk(string n, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // Monitor: compares every visible response cycle against the queue head
    logic pv = 1'b0;
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got data %h", resp_data);
            end else begin
                if (!pv) chk("latency", 512'(cyc), 512'(q[0].at));
                chk("resp_write", 512'(resp_write), 512'(q[0].w));
                chk("resp_err", 512'(resp_err), 512'(q[0].e));
                chk("resp_data", resp_data, q[0].d);
                chk("req_ready_in_resp", 512'(req_ready), 512'(0));
                chk("busy_in_resp", 512'(busy), 512'(1));
                if (resp_ready) void'(q.pop_front());
            end
        end
        pv = rst && resp_valid && !resp_ready;
    end

    task automatic send(input logic w, input logic [31:0] a,
                        input logic [511:0] wd, input logic [511:0] ed,
                        input logic ee, input bit push);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: got 0 want 1");
            req_valid = 1'b0;
            return;
        end
        if (push) q.push_back('{w, ee, ed, cyc + 1 + LAT});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    logic [31:0] a1000 = 32'h0000_1000;
    logic [31:0] a2000 = 32'h0000_2000;
    logic [31:0] a3000 = 32'h0000_3000;
    logic [31:0] a0040 = 32'h0000_0040;
    logic [31:0] a0080 = 32'h0000_0080;

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1;
        req_valid1 = 1'b0; req_addr1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 512'(req_ready), 512'(1));
        chk("rst_resp_valid", 512'(resp_valid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_resp_data", resp_data, 512'd0);
        chk("rst_resp_err", 512'(resp_err), 512'(0));
        chk("rst_resp_write", 512'(resp_write), 512'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        send(1, 32'h0000_1000, 512'hDEADBEEF, 512'd0, 0, 1);
        send(0, 32'h0000_1010, 512'd0, 512'hDEADBEEF, 0, 1);
        send(0, 32'h0000_2000, 512'd0, {16{a2000}}, 0, 1);
        send(0, 32'h0010_0000, 512'd0, 512'd0, 1, 1);
        send(1, 32'h0010_0000, 512'h5555, 512'd0, 1, 1);
        send(0, 32'h0000_0000, 512'd0, 512'd0, 0, 1);
        send(1, 32'h0000_1000, 512'h1234, 512'd0, 0, 1);
        send(0, 32'h0000_103F, 512'd0, 512'h1234, 0, 1);
        drain();

        // Backpressure hold
        resp_ready = 1'b0;
        send(0, 32'h0000_1000, 512'd0, 512'h1234, 0, 1);
        for (int n = 0; n < 50 && !resp_valid; n++) begin
            @(posedge clk); #1;
        end
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_resp_valid", 512'(resp_valid), 512'(1));
            chk("bp_req_ready", 512'(req_ready), 512'(0));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", 512'(req_ready), 512'(1));
        chk("bp_release_valid", 512'(resp_valid), 512'(0));
        chk("bp_release_data", resp_data, 512'h1234);
        drain();

        // Reset during WAIT of a write
        send(1, 32'h0000_3000, 512'hABCDEFABCDEF, 512'd0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_resp_valid", 512'(resp_valid), 512'(0));
        chk("abort_busy", 512'(busy), 512'(0));
        chk("abort_req_ready", 512'(req_ready), 512'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send(0, 32'h0000_3000, 512'd0, {16{a3000}}, 0, 1);
        send(0, 32'h0000_1000, 512'd0, {16{a1000}}, 0, 1);
        drain();
`ifdef MEM_STATS_EN
        chk("stats_rd", 512'(rd_c), 512'(2));
        chk("stats_wr", 512'(wr_c), 512'(0));
        chk("stats_err", 512'(er_c), 512'(0));
`endif

        // LATENCY=1 instance: back-to-back reads
        req_valid1 = 1'b1;
        req_addr1  = a0040;
        @(posedge clk); #1;
        req_addr1 = a0080;
        @(posedge clk); #1;
        chk("l1_valid_a", 512'(resp_valid1), 512'(1));
        chk("l1_data_a", resp_data1, {16{a0040}});
        chk("l1_ready_a", 512'(req_ready1), 512'(0));
        @(posedge clk); #1;
        chk("l1_idle_ready", 512'(req_ready1), 512'(1));
        chk("l1_idle_valid", 512'(resp_valid1), 512'(0));
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        @(posedge clk); #1;
        chk("l1_valid_b", 512'(resp_valid1), 512'(1));
        chk("l1_data_b", resp_data1, {16{a0080}});
        chk("l1_err_b", 512'(resp_err1), 512'(0));
        chk("l1_write_b", 512'(resp_write1), 512'(0));
        @(posedge clk); #1;
        chk("l1_busy_end", 512'(busy1), 512'(0));
`ifdef MEM_STATS_EN
        chk("l1_stats_rd", 512'(rd_c1), 512'(2));
        chk("l1_stats_wr", 512'(wr_c1), 512'(0));
        chk("l1_stats_err", 512'(er_c1), 512'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
